// File: rtl/mu_seq_ctrl_pkg.sv
// Shared types and constants for the four-MU column sequencer.
// Holds the state encoding, the write-back burst length and the operand address helper.
package mu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  localparam int WB_WORDS = 4;
  localparam int MU_RES_W = 18;

  // Operand RAM address for column col, accumulate step k.
  function automatic logic [7:0] op_addr(input logic [3:0] col, input logic [3:0] k,
                                         input int k_len);
    return 8'(col) * 8'(k_len) + 8'(k);
  endfunction

endpackage

// File: rtl/mu_seq_ctrl_dly.sv
// Matches rd_en to the operand RAM latency: a DEPTH-deep shift register carrying
// {rd_en, first_k} that yields mu_en / mu_clr; flush empties it synchronously.
module mu_seq_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic rd_en_i,
  input  logic first_k_i,
  output logic mu_en_o,
  output logic mu_clr_o
);

  logic [DEPTH-1:0] en_q;
  logic [DEPTH-1:0] first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= '0;
      first_q <= '0;
    end else if (flush_i) begin
      en_q    <= '0;
      first_q <= '0;
    end else begin
      en_q[0]    <= rd_en_i;
      first_q[0] <= first_k_i;
      for (int i = 1; i < DEPTH; i++) begin
        en_q[i]    <= en_q[i-1];
        first_q[i] <= first_q[i-1];
      end
    end
  end

  assign mu_en_o  = en_q[DEPTH-1];
  assign mu_clr_o = first_q[DEPTH-1];

endmodule

// File: rtl/mu_seq_ctrl.sv
// Column sequencer for the four-MU datapath: operand reads, MU clear/accumulate,
// drain, write-back pulse and the burst gap, per column, for N_COL columns.
module mu_seq_ctrl
  import mu_seq_ctrl_pkg::*;
#(
  parameter int K_LEN    = 4,
  parameter int N_COL    = 16,
  parameter int READ_LAT = 1,
  parameter int MU_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] a_addr,
  output logic [3:0] coef_sel,
  output logic       mu_clr,
  output logic       mu_en,
  output logic       web,
  output logic       wb_rst_n,
  output logic [3:0] col_cnt,
  output seq_state_e state_dbg
);

  localparam logic [3:0] K_LAST     = 4'(K_LEN - 1);
  localparam logic [3:0] COL_LAST   = 4'(N_COL - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(READ_LAT + MU_LAT - 1);
  localparam logic [2:0] GAP_LOAD   = 3'(WB_WORDS - 2);

  seq_state_e state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [3:0] col_q, col_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rd_en_q, rd_en_d;
  logic       web_q, web_d;
  logic       wb_rst_n_q, wb_rst_n_d;
  logic       abort_hit;
  logic       first_k;

  // Handshake: start is a level sampled only in IDLE (and only without abort); busy rises
  // the cycle after acceptance and stays high through DONE; done is a single-cycle pulse.
  assign abort_hit = abort && (state_q != ST_IDLE);
  assign first_k   = rd_en_q && (k_q == 4'd0);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          k_d     = 4'd0;
          col_d   = 4'd0;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          k_d     = 4'd0;
          cnt_d   = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 3'd0) state_d = ST_WB;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_WB: begin
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == 3'd0) begin
          if (col_q == COL_LAST) begin
            state_d = ST_DONE;
          end else begin
            col_d   = col_q + 4'd1;
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_hit) begin
      state_d = ST_IDLE;
      k_d     = 4'd0;
      col_d   = 4'd0;
      cnt_d   = 3'd0;
    end
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    rd_en_d    = (state_d == ST_RUN);
    web_d      = (state_d == ST_WB);
    wb_rst_n_d = !abort_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      k_q        <= 4'd0;
      col_q      <= 4'd0;
      cnt_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      web_q      <= 1'b0;
      wb_rst_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      web_q      <= web_d;
      wb_rst_n_q <= wb_rst_n_d;
    end
  end

  mu_seq_dly #(
    .DEPTH(READ_LAT)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst),
    .flush_i  (abort_hit),
    .rd_en_i  (rd_en_q),
    .first_k_i(first_k),
    .mu_en_o  (mu_en),
    .mu_clr_o (mu_clr)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign web       = web_q;
  assign wb_rst_n  = wb_rst_n_q;
  assign a_addr    = op_addr(col_q, k_q, K_LEN);
  assign coef_sel  = k_q;
  assign col_cnt   = col_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mu_seq_ctrl.sv
// Directed bench for mu_seq_ctrl: cycle-accurate checks of the column schedule, with a
// scoreboard of expected web cycles, write-back start addresses and done cycles.
module tb_mu_seq_ctrl;
  import mu_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start2 = 1'b0;

  logic       busy, done, rd_en, mu_clr, mu_en, web, wb_rst_n;
  logic [7:0] a_addr;
  logic [3:0] coef_sel, col_cnt;
  seq_state_e state_dbg;

  logic       busy2, done2, rd_en2, mu_clr2, mu_en2, web2, wb_rst_n2;
  logic [7:0] a_addr2;
  logic [3:0] coef_sel2, col_cnt2;
  seq_state_e state_dbg2;

  mu_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_en(rd_en), .a_addr(a_addr), .coef_sel(coef_sel),
    .mu_clr(mu_clr), .mu_en(mu_en), .web(web), .wb_rst_n(wb_rst_n),
    .col_cnt(col_cnt), .state_dbg(state_dbg)
  );

  mu_seq_ctrl #(.K_LEN(1), .N_COL(2), .READ_LAT(3), .MU_LAT(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .busy(busy2), .done(done2), .rd_en(rd_en2), .a_addr(a_addr2), .coef_sel(coef_sel2),
    .mu_clr(mu_clr2), .mu_en(mu_en2), .web(web2), .wb_rst_n(wb_rst_n2),
    .col_cnt(col_cnt2), .state_dbg(state_dbg2)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;
  int t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_web_q[$];
  logic [5:0]  exp_wa_q[$];
  logic [31:0] exp_done_q[$];
  logic [5:0]  wb_ptr = '0;
  int          wr_cnt[64];
  int          web_cnt = 0;

  // Expected web cycles and write-back start addresses of a job whose cycle 0 is t0.
  task automatic push_job(input int n_web, input bit with_done);
    web_cnt = 0;
    for (int c = 0; c < n_web; c++) begin
      exp_web_q.push_back(32'(t0 + 7 + 10 * c));
      exp_wa_q.push_back(6'(4 * c));
    end
    if (with_done) exp_done_q.push_back(32'(t0 + 161));
  endtask

  // Write-back stage model: 4 words per web, address counter cleared by wb_rst_n / rst.
  always @(negedge clk) begin
    if (!rst) begin
      wb_ptr = '0;
    end else begin
      if (web) begin
        web_cnt++;
        chk("web_expected", 32'(exp_web_q.size() > 0), 1);
        if (exp_web_q.size() > 0) begin
          chk("web_cycle", cyc, exp_web_q.pop_front());
          chk("wb_start_addr", 32'(wb_ptr), 32'(exp_wa_q.pop_front()));
        end
        for (int i = 0; i < 4; i++) wr_cnt[wb_ptr + 6'(i)]++;
        wb_ptr = wb_ptr + 6'd4;
      end
      if (!wb_rst_n) wb_ptr = '0;
      if (done) begin
        chk("done_expected", 32'(exp_done_q.size() > 0), 1);
        if (exp_done_q.size() > 0) chk("done_cycle", cyc, exp_done_q.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic at(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_rd_en"}, 32'(rd_en), 0);
    chk({pfx, "_mu_en"}, 32'(mu_en), 0);
    chk({pfx, "_mu_clr"}, 32'(mu_clr), 0);
    chk({pfx, "_web"}, 32'(web), 0);
    chk({pfx, "_a_addr"}, 32'(a_addr), 0);
    chk({pfx, "_coef_sel"}, 32'(coef_sel), 0);
    chk({pfx, "_col_cnt"}, 32'(col_cnt), 0);
    chk({pfx, "_wb_rst_n"}, 32'(wb_rst_n), 1);
    chk({pfx, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    logic rd_x, mu_x;

    repeat (3) @(negedge clk);
    chk_reset_values("rst");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Job 1: single start pulse, full schedule from reset.
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    foreach (wr_cnt[a]) wr_cnt[a] = 0;
    push_job(16, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      at(c);
      rd_x = ((c >= 1) && (c <= 4)) || ((c >= 11) && (c <= 14));
      mu_x = ((c >= 2) && (c <= 5)) || ((c >= 12) && (c <= 15));
      chk($sformatf("j1_rd_en_c%0d", c), 32'(rd_en), 32'(rd_x));
      chk($sformatf("j1_mu_en_c%0d", c), 32'(mu_en), 32'(mu_x));
      chk($sformatf("j1_mu_clr_c%0d", c), 32'(mu_clr), 32'((c == 2) || (c == 12)));
      chk($sformatf("j1_busy_c%0d", c), 32'(busy), 1);
      chk($sformatf("j1_col_c%0d", c), 32'(col_cnt), (c >= 11) ? 1 : 0);
      if (rd_x) begin
        chk($sformatf("j1_a_addr_c%0d", c), 32'(a_addr), (c <= 4) ? c - 1 : c - 7);
        chk($sformatf("j1_coef_c%0d", c), 32'(coef_sel), (c <= 4) ? c - 1 : c - 11);
      end
    end
    at(160);
    chk("j1_busy_c160", 32'(busy), 1);
    chk("j1_done_c160", 32'(done), 0);
    at(161);
    chk("j1_done_c161", 32'(done), 1);
    chk("j1_busy_c161", 32'(busy), 1);
    chk("j1_state_c161", 32'(state_dbg), 32'(ST_DONE));
    at(162);
    chk("j1_busy_c162", 32'(busy), 0);
    chk("j1_done_c162", 32'(done), 0);
    chk("j1_web_count", web_cnt, 16);
    chk("j1_web_left", exp_web_q.size(), 0);
    bad = 0;
    foreach (wr_cnt[a]) if (wr_cnt[a] != 1) bad++;
    chk("j1_addr_written_once_violations", bad, 0);

    // Job 2: start held high; exactly one job, then a second one from cycle 163.
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    push_job(16, 1'b1);
    at(161);
    chk("j2_done_c161", 32'(done), 1);
    at(162);
    chk("j2_busy_c162", 32'(busy), 0);
    chk("j2_state_c162", 32'(state_dbg), 32'(ST_IDLE));
    chk("j2_web_count", web_cnt, 16);
    chk("j2_done_left", exp_done_q.size(), 0);
    t0 = t0 + 162;
    push_job(2, 1'b0);
    at(1);
    chk("j2b_busy_c1", 32'(busy), 1);
    chk("j2b_rd_en_c1", 32'(rd_en), 1);
    chk("j2b_a_addr_c1", 32'(a_addr), 0);
    start = 1'b0;

    // Abort at cycle 25 of the restarted job.
    at(25);
    chk("ab_busy_c25", 32'(busy), 1);
    chk("ab_wb_rst_n_c25", 32'(wb_rst_n), 1);
    abort = 1'b1;
    at(26);
    abort = 1'b0;
    chk("ab_busy_c26", 32'(busy), 0);
    chk("ab_rd_en_c26", 32'(rd_en), 0);
    chk("ab_mu_en_c26", 32'(mu_en), 0);
    chk("ab_web_c26", 32'(web), 0);
    chk("ab_done_c26", 32'(done), 0);
    chk("ab_wb_rst_n_c26", 32'(wb_rst_n), 0);
    chk("ab_state_c26", 32'(state_dbg), 32'(ST_IDLE));
    at(27);
    chk("ab_wb_rst_n_c27", 32'(wb_rst_n), 1);
    chk("ab_busy_c27", 32'(busy), 0);
    chk("ab_web_left", exp_web_q.size(), 0);

    // start together with abort in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("sa_wb_rst_n", 32'(wb_rst_n), 1);

    // Job 3: restart writes from address 0, then rst low mid-job at cycle 40.
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    push_job(4, 1'b0);
    @(negedge clk);
    start = 1'b0;
    at(40);
    chk("j3_busy_c40", 32'(busy), 1);
    chk("j3_col_c40", 32'(col_cnt), 3);
    rst = 1'b0;
    #1;
    chk_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("j3_web_left", exp_web_q.size(), 0);

    // Job 4: normal timing from col 0 after reset release.
    @(negedge clk);
    t0 = cyc;
    start = 1'b1;
    push_job(16, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("j4_rd_en_c1", 32'(rd_en), 1);
    chk("j4_a_addr_c1", 32'(a_addr), 0);
    chk("j4_col_c1", 32'(col_cnt), 0);
    at(2);
    chk("j4_mu_clr_c2", 32'(mu_clr), 1);
    at(162);
    chk("j4_busy_c162", 32'(busy), 0);
    chk("j4_web_count", web_cnt, 16);
    chk("j4_web_left", exp_web_q.size(), 0);
    chk("j4_done_left", exp_done_q.size(), 0);

    // Short configuration: K_LEN=1, READ_LAT=3, MU_LAT=0, N_COL=2.
    @(negedge clk);
    t0 = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      at(c);
      chk($sformatf("s_rd_en_c%0d", c), 32'(rd_en2), 32'((c == 1) || (c == 9)));
      chk($sformatf("s_mu_en_c%0d", c), 32'(mu_en2), 32'((c == 4) || (c == 12)));
      chk($sformatf("s_mu_clr_c%0d", c), 32'(mu_clr2), 32'((c == 4) || (c == 12)));
      chk($sformatf("s_web_c%0d", c), 32'(web2), 32'((c == 5) || (c == 13)));
      chk($sformatf("s_done_c%0d", c), 32'(done2), 32'(c == 17));
      chk($sformatf("s_busy_c%0d", c), 32'(busy2), 32'(c <= 17));
      chk($sformatf("s_wb_rst_n_c%0d", c), 32'(wb_rst_n2), 1);
      if (c == 1 || c == 9) begin
        chk($sformatf("s_a_addr_c%0d", c), 32'(a_addr2), (c == 1) ? 0 : 1);
        chk($sformatf("s_coef_c%0d", c), 32'(coef_sel2), 0);
        chk($sformatf("s_col_c%0d", c), 32'(col_cnt2), (c == 1) ? 0 : 1);
      end
      if (c == 17) chk("s_state_c17", 32'(state_dbg2), 32'(ST_DONE));
    end

    chk("final_web_left", exp_web_q.size(), 0);
    chk("final_done_left", exp_done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
